// File: rtl/ps2_game_pkg.sv
// Shared constants for the PS/2 game-command decoder: command codes, scan codes,
// prefix-state enumeration and the scan-code-to-command lookup.
package ps2_game_pkg;

   localparam int NUM_CMDS = 6;

   localparam logic [2:0] CMD_NONE      = 3'd0;
   localparam logic [2:0] CMD_LEFT      = 3'd1;
   localparam logic [2:0] CMD_RIGHT     = 3'd2;
   localparam logic [2:0] CMD_ROTATE    = 3'd3;
   localparam logic [2:0] CMD_SOFT_DROP = 3'd4;
   localparam logic [2:0] CMD_HARD_DROP = 3'd5;
   localparam logic [2:0] CMD_PAUSE     = 3'd6;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_P     = 8'h4D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } prefix_state_t;

   // Arrow keys only count when E0-prefixed; space and P only when not.
   function automatic logic [2:0] map_scan_code(input logic ext, input logic [7:0] code);
      logic [2:0] cmd;
      cmd = CMD_NONE;
      if (ext) begin
         case (code)
            SC_LEFT:  cmd = CMD_LEFT;
            SC_RIGHT: cmd = CMD_RIGHT;
            SC_UP:    cmd = CMD_ROTATE;
            SC_DOWN:  cmd = CMD_SOFT_DROP;
            default:  cmd = CMD_NONE;
         endcase
      end else begin
         case (code)
            SC_SPACE: cmd = CMD_HARD_DROP;
            SC_P:     cmd = CMD_PAUSE;
            default:  cmd = CMD_NONE;
         endcase
      end
      return cmd;
   endfunction

   function automatic logic is_repeatable(input logic [2:0] cmd);
      return (cmd == CMD_LEFT) || (cmd == CMD_RIGHT) || (cmd == CMD_SOFT_DROP);
   endfunction

   // key_held bit for a command lives at position (code - 1).
   function automatic logic [NUM_CMDS-1:0] cmd_mask(input logic [2:0] cmd);
      logic [NUM_CMDS-1:0] mask;
      mask = '0;
      if (cmd != CMD_NONE)
         mask = NUM_CMDS'(1) << (cmd - 3'd1);
      return mask;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding decoded game commands; a simultaneous push
// and pop is always accepted, even when the queue is full.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic             do_push;
   logic             do_pop;

   assign empty    = (occ == '0);
   assign full     = (occ == (AW+1)'(DEPTH));
   assign count    = occ;
   assign pop_data = mem[rd_ptr];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // NOTE: storage is not reset; occupancy alone decides what is valid, which
   // keeps the array free of reset fan-out.
   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_game_cmd_decoder.sv
// Turns PS/2 scan-code bytes into queued game commands, tracking held keys
// and typematic repeats, with a sticky overflow flag for dropped commands.
module ps2_game_cmd_decoder
   import ps2_game_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [7:0]          key_data,
   input  logic                key_valid,
   output logic [2:0]          cmd_code,
   output logic                cmd_valid,
   input  logic                cmd_ready,
   output logic [NUM_CMDS-1:0] key_held,
   output logic                overflow
);

   prefix_state_t        state;
   prefix_state_t        next_state;
   logic                 dec_en;
   logic                 dec_ext;
   logic                 dec_brk;
   logic [2:0]           dec_cmd;
   logic [NUM_CMDS-1:0]  dec_mask;
   logic                 dec_mapped;
   logic                 cmd_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [2:0]           fifo_head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      next_state = state;
      dec_en     = 1'b0;
      dec_ext    = 1'b0;
      dec_brk    = 1'b0;
      if (key_valid) begin
         unique case (state)
            ST_IDLE: begin
               if (key_data == SC_EXT)      next_state = ST_EXT;
               else if (key_data == SC_BRK) next_state = ST_BRK;
               else                         dec_en     = 1'b1;
            end
            ST_EXT: begin
               if (key_data == SC_BRK) begin
                  next_state = ST_EXT_BRK;
               end else if (key_data != SC_EXT) begin
                  dec_en     = 1'b1;
                  dec_ext    = 1'b1;
                  next_state = ST_IDLE;
               end
            end
            ST_BRK: begin
               dec_en     = 1'b1;
               dec_brk    = 1'b1;
               next_state = ST_IDLE;
            end
            ST_EXT_BRK: begin
               dec_en     = 1'b1;
               dec_ext    = 1'b1;
               dec_brk    = 1'b1;
               next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   assign dec_cmd    = map_scan_code(dec_ext, key_data);
   assign dec_mask   = cmd_mask(dec_cmd);
   assign dec_mapped = dec_en && (dec_cmd != CMD_NONE);

   // A make enqueues on first press, or on typematic repeat for movement keys.
   assign cmd_push = dec_mapped && !dec_brk &&
                     (((key_held & dec_mask) == '0) || is_repeatable(dec_cmd));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         key_held <= '0;
      end else if (dec_mapped) begin
         if (dec_brk) key_held <= key_held & ~dec_mask;
         else         key_held <= key_held | dec_mask;
      end
   end

   assign cmd_valid = !fifo_empty;
   assign fifo_pop  = cmd_valid && cmd_ready;
   assign cmd_code  = fifo_empty ? CMD_NONE : fifo_head;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         overflow <= 1'b0;
      else if (cmd_push && fifo_full && !fifo_pop)
         overflow <= 1'b1;
   end

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (3)
   ) u_cmd_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (cmd_push),
      .push_data (dec_cmd),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

endmodule

// File: tb/tb_ps2_game_cmd_decoder.sv
// Randomized and directed bench for ps2_game_cmd_decoder against a queue-based
// reference model built directly from the key mapping and queueing rules.
module tb_ps2_game_cmd_decoder;

   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] key_data = 8'h00;
   logic       key_valid = 1'b0;
   logic       cmd_ready = 1'b0;
   logic [2:0] cmd_code;
   logic       cmd_valid;
   logic [5:0] key_held;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int       q[$];
   bit [5:0] m_held;
   bit       m_ovf;
   bit       m_ext;
   bit       m_brk;

   always #5 clock = ~clock;

   ps2_game_cmd_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .key_data  (key_data),
      .key_valid (key_valid),
      .cmd_code  (cmd_code),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .key_held  (key_held),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   function automatic int lookup(input bit ext, input logic [7:0] b);
      if (ext) begin
         case (b)
            8'h6B:   return 1;
            8'h74:   return 2;
            8'h75:   return 3;
            8'h72:   return 4;
            default: return 0;
         endcase
      end
      case (b)
         8'h29:   return 5;
         8'h4D:   return 6;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      m_held = '0;
      m_ovf  = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
   endtask

   task automatic model_clock(input bit kv, input logic [7:0] kd, input bit rdy);
      bit pop_ok;
      bit brk;
      bit do_push;
      int c;
      pop_ok  = (q.size() > 0) && rdy;
      c       = 0;
      brk     = 1'b0;
      do_push = 1'b0;
      if (kv) begin
         if (!m_brk && kd == 8'hE0)      m_ext = 1'b1;
         else if (!m_brk && kd == 8'hF0) m_brk = 1'b1;
         else begin
            c     = lookup(m_ext, kd);
            brk   = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end
      if (c != 0) begin
         if (brk) m_held[c-1] = 1'b0;
         else begin
            do_push = !m_held[c-1] || (c == 1) || (c == 2) || (c == 4);
            m_held[c-1] = 1'b1;
         end
      end
      if (pop_ok) void'(q.pop_front());
      if (do_push) begin
         if (q.size() < DEPTH) q.push_back(c);
         else                  m_ovf = 1'b1;
      end
   endtask

   task automatic check_outputs();
      check("cmd_valid", cmd_valid, (q.size() > 0) ? 1 : 0);
      check("cmd_code",  cmd_code,  (q.size() > 0) ? q[0] : 0);
      check("key_held",  key_held,  m_held);
      check("overflow",  overflow,  m_ovf);
   endtask

   task automatic step(input bit kv, input logic [7:0] kd, input bit rdy);
      @(negedge clock);
      check_outputs();
      key_valid = kv;
      key_data  = kd;
      cmd_ready = rdy;
      @(posedge clock);
      model_clock(kv, kd, rdy);
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [2:0] c,
                             input logic [5:0] h, input logic o);
      #1;
      check({tag, "_valid"}, cmd_valid, v);
      check({tag, "_code"},  cmd_code,  c);
      check({tag, "_held"},  key_held,  h);
      check({tag, "_ovf"},   overflow,  o);
   endtask

   task automatic do_reset();
      @(negedge clock);
      key_valid = 1'b0;
      cmd_ready = 1'b0;
      resetn    = 1'b0;
      #1;
      check("rst_valid", cmd_valid, 0);
      check("rst_code",  cmd_code,  0);
      check("rst_held",  key_held,  0);
      check("rst_ovf",   overflow,  0);
      model_reset();
      #1 resetn = 1'b1;
   endtask

   logic [7:0] picks [8] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h4D};

   initial begin
      model_reset();

      // Extended LEFT make
      do_reset();
      step(1, 8'hE0, 0);
      step(1, 8'h6B, 0);
      expect_out("left_make", 1, 3'd1, 6'b000001, 0);
      step(0, 8'h00, 0);

      // HARD_DROP pressed, repeated, released: one entry only
      do_reset();
      step(1, 8'h29, 0);
      step(1, 8'h29, 0);
      expect_out("hard_rep", 1, 3'd5, 6'b010000, 0);
      step(1, 8'hF0, 0);
      step(1, 8'h29, 0);
      expect_out("hard_brk", 1, 3'd5, 6'b000000, 0);
      step(0, 8'h00, 1);
      expect_out("hard_drain", 0, 3'd0, 6'b000000, 0);

      // RIGHT typematic repeats queue three entries
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1, 8'hE0, 0);
         step(1, 8'h74, 0);
      end
      expect_out("right_rep", 1, 3'd2, 6'b000010, 0);
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);
      expect_out("right_pop2", 1, 3'd2, 6'b000010, 0);
      step(0, 8'h00, 1);
      expect_out("right_pop3", 0, 3'd0, 6'b000010, 0);

      // Six distinct presses overflow a depth-4 queue
      do_reset();
      step(1, 8'hE0, 0); step(1, 8'h6B, 0);
      step(1, 8'hE0, 0); step(1, 8'h74, 0);
      step(1, 8'hE0, 0); step(1, 8'h75, 0);
      step(1, 8'hE0, 0); step(1, 8'h72, 0);
      step(1, 8'h29, 0);
      step(1, 8'h4D, 0);
      expect_out("ovf_full", 1, 3'd1, 6'b111111, 1);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
      expect_out("ovf_drained", 0, 3'd0, 6'b111111, 1);

      // Reset discards a pending E0 prefix
      do_reset();
      step(1, 8'hE0, 0);
      do_reset();
      step(1, 8'h6B, 0);
      expect_out("prefix_rst", 0, 3'd0, 6'b000000, 0);
      step(0, 8'h00, 0);

      // Push and pop together on a full queue
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, 8'hE0, 0);
         step(1, 8'h6B, 0);
      end
      expect_out("full4", 1, 3'd1, 6'b000001, 0);
      step(1, 8'hE0, 0);
      step(1, 8'h75, 1);
      expect_out("full_pushpop", 1, 3'd1, 6'b000101, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
      expect_out("full_tail", 1, 3'd3, 6'b000101, 0);
      step(0, 8'h00, 1);
      expect_out("full_empty", 0, 3'd0, 6'b000101, 0);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] b;
         int sel;
         if ($urandom_range(299) == 0) do_reset();
         sel = int'($urandom_range(9));
         if (sel < 8) b = picks[sel];
         else         b = 8'($urandom);
         step(bit'($urandom_range(1)), b, ($urandom_range(3) == 0));
      end
      step(0, 8'h00, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_game_cmd_decoder.md
PS2_GAME_CMD_DECODER -- requirements
Module: ps2_game_cmd_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-002 SHALL have port clock  input  1  the single system clock; all state is on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port key_data  input  8  received PS/2 scan-code byte from the PS/2 interface.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe marking key_data valid.
REQ-006 SHALL have port cmd_code  output  3  head-of-queue game command.
REQ-007 SHALL have port cmd_valid  output  1  queue non-empty.
REQ-008 SHALL have port cmd_ready  input  1  consumer (vga_controller/processor) accepts head.
REQ-009 SHALL have port key_held  output  6  level per command, bit (code-1), set on make and cleared on break.
REQ-010 SHALL have port overflow  output  1  sticky flag: a command was dropped on a full queue.

Function
REQ-011 Command codes SHALL be: 0 NONE (never queued), 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 HARD_DROP, 6 PAUSE.
REQ-012 Mapping SHALL be: E0 6B->LEFT, E0 74->RIGHT, E0 75->ROTATE, E0 72->SOFT_DROP, 29 (space)->HARD_DROP, 4D (P)->PAUSE; any other code is unmapped.
REQ-013 Prefix FSM states SHALL be IDLE, EXT, BRK, EXT_BRK; it advances only on cycles with key_valid=1.
REQ-014 IDLE: E0->EXT, F0->BRK, other byte->decode as non-extended make, stay IDLE.
REQ-015 EXT: F0->EXT_BRK, E0->stay EXT, other byte->decode as extended make, go IDLE.
REQ-016 BRK: decode as non-extended break, go IDLE; EXT_BRK: decode as extended break, go IDLE (E0/F0 bytes in these states are treated as ordinary codes).
REQ-017 A make of a mapped key SHALL set its key_held bit; a break SHALL clear it; unmapped makes/breaks SHALL change nothing.
REQ-018 A mapped make SHALL enqueue its command when key_held bit was 0 (first press), or when the bit was 1 and the command is LEFT, RIGHT or SOFT_DROP (typematic repeat); repeats of ROTATE, HARD_DROP, PAUSE SHALL be discarded.
REQ-019 Latency: final byte strobed in cycle N SHALL give key_held update and cmd_valid=1 (if queue was empty) in cycle N+1.
REQ-020 Queue SHALL be FIFO order; cmd_code SHALL equal the oldest entry whenever cmd_valid=1, and SHALL read 0 when empty.
REQ-021 Pop SHALL occur on every cycle with cmd_valid=1 and cmd_ready=1; cmd_ready while empty SHALL have no effect.
REQ-022 Push on full without simultaneous pop SHALL drop the new command and set overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-023 Push and pop on a one-entry queue in the same cycle SHALL leave one entry (the new command).
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-025 overflow SHALL remain 1 until reset.

Reset
REQ-026 resetn=0 SHALL asynchronously force FSM to IDLE, queue empty, cmd_valid=0, cmd_code=0, key_held=0, overflow=0.
REQ-027 A partial prefix sequence interrupted by reset SHALL be discarded; decoding resumes in IDLE after deassertion.
REQ-028 Reset deassertion SHALL be the only recovery mechanism; no soft clear exists.

Structure
REQ-029 Package ps2_game_pkg SHALL hold command code constants, scan-code constants (E0, F0, six key codes) and the FSM state enumeration.
REQ-030 The queue SHALL be a separate sub-module cmd_fifo (parameterised depth, width 3, push/pop/full/empty/count).
REQ-031 Decoder SHALL instantiate exactly one cmd_fifo; no other sub-modules.

Verification
REQ-032 Bytes E0 6B, cmd_ready=0 -> cmd_valid=1 cycle after 6B, cmd_code=1, key_held=000001.
REQ-033 29, 29, F0 29 -> exactly one HARD_DROP (5) queued; key_held[4] 1 then 0 after break.
REQ-034 E0 74 three times with cmd_ready=0 -> three RIGHT (2) entries, popped in order when cmd_ready=1, then cmd_valid=0.
REQ-035 FIFO_DEPTH=4, six distinct first-press makes with cmd_ready=0 -> four entries kept, overflow=1, stays 1 after queue drained.
REQ-036 E0 then resetn pulse low, then 6B -> no command queued (6B unmapped non-extended), FSM IDLE, all outputs 0.
REQ-037 Full queue, make strobe with cmd_ready=1 same cycle -> occupancy stays 4, new code at tail, overflow=0.
